xer_cr_unit: RTL and testbench

- Sits directly downstream of the ALU in the EX stage. Consumes the ALU result flags (CA, OV, SO, CR0) and the compare result.
- Holds them for one cycle in an EX/WB register, then commits them to the architectural XER[SO,OV,CA] and the 32-bit CR.
- Also executes mtcrf, mtxer and mcrxr.
- Forwards the pending CA/SO back to the ALU's XER_CA/XER_SO inputs so back-to-back adde/subfe/OE instructions see correct values.

---
 rtl/xer_cr_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_xer_cr_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xer_cr_unit.sv
// xer_cr_unit
//
// Sits after the ALU in EX. Each valid EX instruction is decoded into a
// self-contained update (which CR fields to write and with what, which XER
// bits to write and with what). The update is held for one cycle in the
// EX/WB register and then committed to the architectural CR and XER[SO,OV,CA].
// Pending CA/SO are forwarded back to the ALU so dependent instructions
// issued back-to-back see the correct carry and summary-overflow.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   ex_valid          EX instruction valid
//   stall             freeze WB register, block commit
//   flush             kill EX capture and the WB entry
//   alu_c             ALU result; compare flags LT,GT,EQ in alu_c[2:0]
//   alu_ca/ov/so      ALU flag outputs
//   alu_cr0           ALU CR0 {LT,GT,EQ,SO}, LT in the MSB
//   ca_wr, ov_wr, rc, cmp_wr   arithmetic update enables
//   crf               target CR field for compare / mcrxr
//   mtcrf_wr, crm     mtcrf and its field mask (crm[i] selects field i)
//   mtxer_wr          mtxer
//   mcrxr_wr          mcrxr
//   gpr_data          rS value for mtcrf / mtxer
//   cr                committed CR (CR bit 0 = cr[31])
//   xer_so/ov/ca      committed XER bits
//   fwd_so, fwd_ca    forwarded XER values for the ALU
//   wb_valid          WB register holds a live entry

module xer_cr_unit #(
  parameter int CR_WIDTH = 32,
  parameter int FLD_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [31:0]            alu_c,
  input  logic                   alu_ca,
  input  logic                   alu_ov,
  input  logic                   alu_so,
  input  logic [3:0]             alu_cr0,
  input  logic                   ca_wr,
  input  logic                   ov_wr,
  input  logic                   rc,
  input  logic                   cmp_wr,
  input  logic [FLD_W-1:0]       crf,
  input  logic                   mtcrf_wr,
  input  logic [CR_WIDTH/4-1:0]  crm,
  input  logic                   mtxer_wr,
  input  logic                   mcrxr_wr,
  input  logic [31:0]            gpr_data,
  output logic [CR_WIDTH-1:0]    cr,
  output logic                   xer_so,
  output logic                   xer_ov,
  output logic                   xer_ca,
  output logic                   fwd_so,
  output logic                   fwd_ca,
  output logic                   wb_valid
);

  localparam int NUM_FLD = CR_WIDTH / 4;

  // Field-array view of the CR: element 0 lands in the MSBs, which matches
  // the big-endian field numbering (field 0 = CR[0:3] = cr[31:28]).
  typedef logic [0:NUM_FLD-1][3:0] cr_fld_t;

  // Architectural state
  cr_fld_t cr_q;
  logic    xer_so_q;
  logic    xer_ov_q;
  logic    xer_ca_q;

  // EX/WB register: valid + decoded update payload
  logic               wb_valid_q;
  logic [NUM_FLD-1:0] wb_fld_we;
  cr_fld_t            wb_fld;
  logic               wb_so_we;
  logic               wb_ov_we;
  logic               wb_ca_we;
  logic               wb_so;
  logic               wb_ov;
  logic               wb_ca;

  // Decoded update for the instruction currently in EX
  logic [NUM_FLD-1:0] d_fld_we;
  cr_fld_t            d_fld;
  logic               d_so_we;
  logic               d_ov_we;
  logic               d_ca_we;
  logic               d_so;
  logic               d_ov;
  logic               d_ca;

  cr_fld_t            gpr_fld;
  logic               fwd_act;
  logic               fwd_ov;
  logic               commit;

  // Only the compare flag bits of the ALU result are consumed here.
  logic               alu_c_unused;
  assign alu_c_unused = ^alu_c[31:3];

  assign gpr_fld = cr_fld_t'(gpr_data);

  // --------------------------------------------------------------------------
  // Forwarding. A flushed entry must never be consumed, so forwarding is
  // gated by flush; during a stall the entry is still live and forwards.
  // OV is forwarded internally only, for mcrxr.
  // --------------------------------------------------------------------------
  assign fwd_act = wb_valid_q && !flush;
  assign fwd_so  = (fwd_act && wb_so_we) ? wb_so : xer_so_q;
  assign fwd_ov  = (fwd_act && wb_ov_we) ? wb_ov : xer_ov_q;
  assign fwd_ca  = (fwd_act && wb_ca_we) ? wb_ca : xer_ca_q;

  assign commit  = wb_valid_q && !stall && !flush;

  // --------------------------------------------------------------------------
  // Decode. Special ops are mutually exclusive by priority and override every
  // arithmetic enable; arithmetic enables combine freely. The compare is
  // applied after Rc so that a compare into field 0 wins over CR0.
  // --------------------------------------------------------------------------
  always_comb begin
    d_fld_we = '0;
    d_fld    = '0;
    d_so_we  = 1'b0;
    d_ov_we  = 1'b0;
    d_ca_we  = 1'b0;
    d_so     = 1'b0;
    d_ov     = 1'b0;
    d_ca     = 1'b0;

    if (mtcrf_wr) begin
      d_fld_we = crm;
      d_fld    = gpr_fld;
    end else if (mtxer_wr) begin
      d_so_we = 1'b1;
      d_ov_we = 1'b1;
      d_ca_we = 1'b1;
      d_so    = gpr_data[31];
      d_ov    = gpr_data[30];
      d_ca    = gpr_data[29];
    end else if (mcrxr_wr) begin
      d_fld_we[crf] = 1'b1;
      d_fld[crf]    = {fwd_so, fwd_ov, fwd_ca, 1'b0};
      d_so_we       = 1'b1;
      d_ov_we       = 1'b1;
      d_ca_we       = 1'b1;
    end else begin
      if (ca_wr) begin
        d_ca_we = 1'b1;
        d_ca    = alu_ca;
      end
      if (ov_wr) begin
        // alu_so already includes the forwarded SO, so it is the new sticky SO
        d_ov_we = 1'b1;
        d_so_we = 1'b1;
        d_ov    = alu_ov;
        d_so    = alu_so;
      end
      if (rc) begin
        d_fld_we[0] = 1'b1;
        d_fld[0]    = {alu_cr0[3:1], ov_wr ? alu_so : fwd_so};
      end
      if (cmp_wr) begin
        d_fld_we[crf] = 1'b1;
        d_fld[crf]    = {alu_c[2:0], fwd_so};
      end
    end
  end

  // --------------------------------------------------------------------------
  // EX/WB register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_fld_we  <= '0;
      wb_fld     <= '0;
      wb_so_we   <= 1'b0;
      wb_ov_we   <= 1'b0;
      wb_ca_we   <= 1'b0;
      wb_so      <= 1'b0;
      wb_ov      <= 1'b0;
      wb_ca      <= 1'b0;
    end else if (flush) begin
      wb_valid_q <= 1'b0;
    end else if (!stall) begin
      wb_valid_q <= ex_valid;
      wb_fld_we  <= d_fld_we;
      wb_fld     <= d_fld;
      wb_so_we   <= d_so_we;
      wb_ov_we   <= d_ov_we;
      wb_ca_we   <= d_ca_we;
      wb_so      <= d_so;
      wb_ov      <= d_ov;
      wb_ca      <= d_ca;
    end
  end

  // --------------------------------------------------------------------------
  // Architectural commit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q     <= '0;
      xer_so_q <= 1'b0;
      xer_ov_q <= 1'b0;
      xer_ca_q <= 1'b0;
    end else if (commit) begin
      for (int i = 0; i < NUM_FLD; i++) begin
        if (wb_fld_we[i]) cr_q[i] <= wb_fld[i];
      end
      if (wb_so_we) xer_so_q <= wb_so;
      if (wb_ov_we) xer_ov_q <= wb_ov;
      if (wb_ca_we) xer_ca_q <= wb_ca;
    end
  end

  assign cr       = CR_WIDTH'(cr_q);
  assign xer_so   = xer_so_q;
  assign xer_ov   = xer_ov_q;
  assign xer_ca   = xer_ca_q;
  assign wb_valid = wb_valid_q;

endmodule

// File: tb/tb_xer_cr_unit.sv
// Bench for xer_cr_unit: a state-level model (architectural state plus the
// full post-instruction state of the single pending entry) is compared with
// the DUT every cycle; directed scenarios add literal expectations.
module tb_xer_cr_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, stall, flush;
  logic [31:0] alu_c;
  logic        alu_ca, alu_ov, alu_so;
  logic [3:0]  alu_cr0;
  logic        ca_wr, ov_wr, rc, cmp_wr;
  logic [2:0]  crf;
  logic        mtcrf_wr;
  logic [7:0]  crm;
  logic        mtxer_wr, mcrxr_wr;
  logic [31:0] gpr_data;
  logic [31:0] cr;
  logic        xer_so, xer_ov, xer_ca, fwd_so, fwd_ca, wb_valid;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] cr;
    logic        so;
    logic        ov;
    logic        ca;
  } st_t;

  st_t  m_arch, m_pend;
  logic m_pv;

  xer_cr_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .alu_c(alu_c), .alu_ca(alu_ca), .alu_ov(alu_ov), .alu_so(alu_so),
    .alu_cr0(alu_cr0), .ca_wr(ca_wr), .ov_wr(ov_wr), .rc(rc), .cmp_wr(cmp_wr),
    .crf(crf), .mtcrf_wr(mtcrf_wr), .crm(crm), .mtxer_wr(mtxer_wr),
    .mcrxr_wr(mcrxr_wr), .gpr_data(gpr_data), .cr(cr), .xer_so(xer_so),
    .xer_ov(xer_ov), .xer_ca(xer_ca), .fwd_so(fwd_so), .fwd_ca(fwd_ca),
    .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // CR field f (big-endian numbering) lives in bits [31-4f -: 4]
  function automatic logic [31:0] set_fld(input logic [31:0] c, input int f, input logic [3:0] v);
    logic [31:0] r;
    r = c;
    r[31-4*f -: 4] = v;
    return r;
  endfunction

  // State after executing the EX instruction on top of state v
  function automatic st_t apply(input st_t v);
    st_t r;
    r = v;
    if (mtcrf_wr) begin
      for (int i = 0; i < 8; i++)
        if (crm[i]) r.cr = set_fld(r.cr, i, gpr_data[31-4*i -: 4]);
    end else if (mtxer_wr) begin
      r.so = gpr_data[31];
      r.ov = gpr_data[30];
      r.ca = gpr_data[29];
    end else if (mcrxr_wr) begin
      r.cr = set_fld(r.cr, int'(crf), {v.so, v.ov, v.ca, 1'b0});
      r.so = 1'b0;
      r.ov = 1'b0;
      r.ca = 1'b0;
    end else begin
      if (ca_wr) r.ca = alu_ca;
      if (rc) r.cr = set_fld(r.cr, 0, {alu_cr0[3], alu_cr0[2], alu_cr0[1], ov_wr ? alu_so : v.so});
      if (cmp_wr) r.cr = set_fld(r.cr, int'(crf), {alu_c[2], alu_c[1], alu_c[0], v.so});
      if (ov_wr) begin
        r.ov = alu_ov;
        r.so = alu_so;
      end
    end
    return r;
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; stall = 0; flush = 0; alu_c = 0; alu_ca = 0; alu_ov = 0;
    alu_so = 0; alu_cr0 = 0; ca_wr = 0; ov_wr = 0; rc = 0; cmp_wr = 0; crf = 0;
    mtcrf_wr = 0; crm = 0; mtxer_wr = 0; mcrxr_wr = 0; gpr_data = 0;
  endtask

  // Called at a negedge with inputs already driven; compares, advances one
  // clock and returns at the following negedge.
  task automatic cycle();
    st_t  view, n_arch, n_pend;
    logic n_pv;
    #1;
    view = (m_pv && !flush) ? m_pend : m_arch;
    chk("cr", cr, m_arch.cr);
    chk("xer_so", {31'b0, xer_so}, {31'b0, m_arch.so});
    chk("xer_ov", {31'b0, xer_ov}, {31'b0, m_arch.ov});
    chk("xer_ca", {31'b0, xer_ca}, {31'b0, m_arch.ca});
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, m_pv});
    chk("fwd_so", {31'b0, fwd_so}, {31'b0, view.so});
    chk("fwd_ca", {31'b0, fwd_ca}, {31'b0, view.ca});
    n_arch = m_arch; n_pend = m_pend; n_pv = m_pv;
    if (m_pv && !stall && !flush) n_arch = m_pend;
    if (flush) n_pv = 1'b0;
    else if (!stall) begin
      n_pv = ex_valid;
      if (ex_valid) n_pend = apply(view);
    end
    @(posedge clk);
    m_arch = n_arch; m_pend = n_pend; m_pv = n_pv;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    m_arch = '0; m_pend = '0; m_pv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Carry chain
    ex_valid = 1; ca_wr = 1; alu_ca = 1; cycle();
    alu_ca = 0; #1;
    chk("carry_fwd_c1", {31'b0, fwd_ca}, 32'd1);
    chk("carry_xer_c1", {31'b0, xer_ca}, 32'd0);
    cycle();
    idle_inputs(); #1;
    chk("carry_xer_c2", {31'b0, xer_ca}, 32'd1);
    cycle();
    chk("carry_xer_c3", {31'b0, xer_ca}, 32'd0);
    cycle();

    // Sticky SO then Rc
    do_reset();
    ex_valid = 1; ov_wr = 1; alu_ov = 1; alu_so = 1; cycle();
    alu_ov = 0; alu_so = 1; cycle();
    idle_inputs(); ex_valid = 1; rc = 1; alu_cr0 = 4'b0100; #1;
    chk("so_ov_c2", {31'b0, xer_ov}, 32'd1);
    chk("so_so_c2", {31'b0, xer_so}, 32'd1);
    cycle();
    idle_inputs(); #1;
    chk("so_ov_c3", {31'b0, xer_ov}, 32'd0);
    chk("so_so_c3", {31'b0, xer_so}, 32'd1);
    cycle();
    chk("so_cr0", {28'b0, cr[31:28]}, 32'h5);
    cycle();

    // Compare then mtcrf
    do_reset();
    ex_valid = 1; cmp_wr = 1; crf = 5; alu_c = 32'h4; cycle();
    idle_inputs(); ex_valid = 1; mtcrf_wr = 1; crm = 8'b1000_0001; gpr_data = 32'hA000_000F;
    cycle();
    idle_inputs(); #1;
    chk("cmp_fld5", {28'b0, cr[11:8]}, 32'h8);
    cycle();
    chk("mtcrf_f0", {28'b0, cr[31:28]}, 32'hA);
    chk("mtcrf_f7", {28'b0, cr[3:0]}, 32'hF);
    chk("mtcrf_f5", {28'b0, cr[11:8]}, 32'h8);
    cycle();

    // mtxer then mcrxr into field 2
    do_reset();
    ex_valid = 1; mtxer_wr = 1; gpr_data = 32'hA000_0000; cycle();
    idle_inputs(); ex_valid = 1; mcrxr_wr = 1; crf = 2; cycle();
    idle_inputs(); #1;
    chk("mtxer_so", {31'b0, xer_so}, 32'd1);
    chk("mtxer_ca", {31'b0, xer_ca}, 32'd1);
    cycle();
    chk("mcrxr_fld2", {28'b0, cr[23:20]}, 32'hA);
    chk("mcrxr_xer", {29'b0, xer_so, xer_ov, xer_ca}, 32'd0);
    cycle();

    // Async reset while a stalled entry is live
    ex_valid = 1; ca_wr = 1; alu_ca = 1; cycle();
    idle_inputs(); stall = 1; #1;
    chk("rst_pre_wbv", {31'b0, wb_valid}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rst_cr", cr, 32'h0);
    chk("rst_xer", {29'b0, xer_so, xer_ov, xer_ca}, 32'd0);
    chk("rst_wbv", {31'b0, wb_valid}, 32'd0);
    m_arch = '0; m_pend = '0; m_pv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; stall = 0;
    cycle(); cycle();
    chk("rst_no_commit", {31'b0, xer_ca}, 32'd0);

    // Stall then flush+stall
    ex_valid = 1; ca_wr = 1; alu_ca = 1; cycle();
    idle_inputs(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_fwd", {31'b0, fwd_ca}, 32'd1);
      chk("stall_xer", {31'b0, xer_ca}, 32'd0);
      cycle();
    end
    flush = 1; #1;
    chk("flush_fwd", {31'b0, fwd_ca}, 32'd0);
    cycle();
    idle_inputs(); #1;
    chk("flush_wbv", {31'b0, wb_valid}, 32'd0);
    chk("flush_xer", {31'b0, xer_ca}, 32'd0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ex_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      alu_c    = $urandom;
      alu_ca   = 1'($urandom_range(0, 1));
      alu_ov   = 1'($urandom_range(0, 1));
      alu_so   = 1'($urandom_range(0, 1));
      alu_cr0  = 4'($urandom_range(0, 15));
      ca_wr    = 1'($urandom_range(0, 1));
      ov_wr    = 1'($urandom_range(0, 1));
      rc       = 1'($urandom_range(0, 1));
      cmp_wr   = 1'($urandom_range(0, 1));
      crf      = 3'($urandom_range(0, 7));
      mtcrf_wr = ($urandom_range(0, 7) == 0);
      crm      = 8'($urandom_range(0, 255));
      mtxer_wr = ($urandom_range(0, 7) == 0);
      mcrxr_wr = ($urandom_range(0, 7) == 0);
      gpr_data = $urandom;
      cycle();
    end

    idle_inputs();
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
